bin27_to_dec8: RTL
==================

Name: bin27_to_dec8

Overview:
- Sequential binary-to-BCD converter: 27-bit unsigned binary in, 8 packed BCD digits out.
- Uses shift-and-add-3 (double dabble), one bit per clock.
- Sits downstream of the arithmetic stage. It turns binary results, e.g. from the BCD-to-binary converter, back into decimal for display and readout.
- Same st/ok strobe handshake as the rest of the conversion chain.

Parameters:
- None. Widths are fixed: 27-bit binary in, 8 BCD digits (32 bits) out, 27 iterations.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- st  input  1  start strobe; BIN is sampled on the clock edge where st=1
- BIN  input  27  unsigned binary operand; needs to be valid only in the st cycle
- DEC  output  32  result, packed BCD; DEC[3:0] is units, DEC[31:28] is 10^7
- ok  output  1  one-cycle pulse: DEC/ovf updated this cycle
- busy  output  1  high while a conversion is in progress
- ovf  output  1  last conversion exceeded 99_999_999

Behaviour:
- Reset (async, rst=1): DEC=0, ok=0, busy=0, ovf=0, iteration counter=0, shift/BCD work registers=0. Reset mid-conversion aborts it; no ok is produced.
- Internal state:
  - 27-bit shift register SH
  - 36-bit BCD accumulator ACC (9 digits, so values up to 134_217_727 are representable)
  - 5-bit counter CNT
- Start edge (st=1, E0):
  - SH<=BIN, ACC<=0, CNT<=0, busy<=1, ok<=0.
  - DEC and ovf keep their previous values.
- Iteration edges E1..E27, while busy:
  - In ACC, add 3 to every digit that is >=5.
  - Then shift {ACC,SH} left by 1, with the MSB of SH entering ACC[0].
  - CNT<=CNT+1.
- Completion, at E27 (the edge where CNT==26):
  - busy<=0, ok<=1.
  - If the final ACC[35:32]==0: DEC<=ACC[31:0], ovf<=0.
  - Else: DEC<=32'h9999_9999 (saturate), ovf<=1.
- At E28, ok<=0. ok is never wider than one cycle.
- Latency: ok is high in the cycle after edge E27, 27 clocks after the st edge. Throughput is one conversion per 28 cycles minimum; st at E28 is legal.
- st while busy: restarts immediately, as at E0, with the new BIN. The old conversion is discarded and gives no ok.
- st in the completion edge (CNT==26): st wins. Restart happens, no ok pulse, DEC not updated.
- st held high for several cycles: each edge reloads, and conversion proceeds only after st falls. ok follows 27 edges after the last st edge.
- When idle (busy=0, st=0): all registers hold; ok=0.
- BIN is don't-care outside the st cycle.

Optional Feature:
- Macro: BIN27_TO_DEC8_LZB_EN (leading-zero blanking).
- Defined:
  - At completion, every digit above the most significant nonzero digit is written as 4'hF (the blank code for the 7-segment driver).
  - Digit 0 is never blanked, so value 0 gives 32'hFFFF_FFF0.
  - The saturated overflow value 32'h9999_9999 is unaffected.
  - ovf, ok, busy and timing are identical to the non-blanked build.
- Undefined: DEC is plain packed BCD with leading zeros as 4'h0. There is no blanking logic.

Test Plan:
1. rst pulse, then st with BIN=12_345_678 -> busy=1 for 27 cycles; ok=1 exactly in cycle 27 after st; DEC=32'h1234_5678; ovf=0; ok low next cycle. With LZB_EN, same result since there are no leading zeros.
2. BIN=0, then BIN=99_999_999, then BIN=7 -> DEC=32'h0000_0000, 32'h9999_9999, 32'h0000_0007, all ovf=0. With LZB_EN: 32'hFFFF_FFF0, 32'h9999_9999, 32'hFFFF_FFF7.
3. BIN=100_000_000, then BIN=27'h7FF_FFFF -> ovf=1 and DEC=32'h9999_9999 both times. A following BIN=5 gives ovf=0, DEC=32'h0000_0005.
4. st with BIN=11_111_111; at cycle 10, st with BIN=42 -> no ok for the first operand; one ok 27 cycles after the second st; DEC=32'h0000_0042.
5. st with BIN=55_555_555; assert rst at cycle 15 -> DEC=0, busy=0, ok stays 0, ovf=0. A new st after rst release converts normally.
6. Back-to-back: st at E0 (BIN=1) and again at E28 (BIN=2) -> ok at E27 with DEC=32'h1, ok at E55 with DEC=32'h2. No extra ok pulses, and busy gaps are correct.

Source files
------------

// File: rtl/bin27_to_dec8.sv
// Sequential 27-bit binary to 8-digit packed BCD converter (double dabble, one bit per clock).
// Optional leading-zero blanking is enabled by defining BIN27_TO_DEC8_LZB_EN.
module bin27_to_dec8 (
   input  logic        clk,
   input  logic        rst,
   input  logic        st,
   input  logic [26:0] BIN,
   output logic [31:0] DEC,
   output logic        ok,
   output logic        busy,
   output logic        ovf
);

   logic [26:0] sh_r;
   logic [35:0] acc_r;
   logic [4:0]  cnt_r;
   logic [31:0] dec_r;
   logic        ok_r;
   logic        busy_r;
   logic        ovf_r;

   logic [35:0] adj_s;
   logic [35:0] acc_next_s;
   logic [26:0] sh_next_s;
   logic [31:0] res_dec_s;
   logic        res_ovf_s;

   function automatic logic [35:0] add3_digits(input logic [35:0] a);
      logic [35:0] r;
      r = a;
      for (int i = 0; i < 9; i++) begin
         if (a[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = a[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = a[4*i +: 4];
         end
      end
      return r;
   endfunction

`ifdef BIN27_TO_DEC8_LZB_EN
   // Digits above the most significant nonzero digit become the blank code; digit 0 always shows.
   function automatic logic [31:0] format_dec(input logic [31:0] d);
      logic [31:0] r;
      logic        seen;
      r    = d;
      seen = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         if (d[4*i +: 4] != 4'h0) begin
            seen = 1'b1;
         end else begin
            seen = seen;
         end
         if (!seen) begin
            r[4*i +: 4] = 4'hF;
         end else begin
            r[4*i +: 4] = d[4*i +: 4];
         end
      end
      return r;
   endfunction
`else
   function automatic logic [31:0] format_dec(input logic [31:0] d);
      return d;
   endfunction
`endif

   // One double-dabble step and the result that would be published on the final step.
   always_comb begin
      adj_s      = add3_digits(acc_r);
      acc_next_s = {adj_s[34:0], sh_r[26]};
      sh_next_s  = {sh_r[25:0], 1'b0};
      if (acc_next_s[35:32] == 4'h0) begin
         res_dec_s = format_dec(acc_next_s[31:0]);
         res_ovf_s = 1'b0;
      end else begin
         res_dec_s = 32'h9999_9999;
         res_ovf_s = 1'b1;
      end
   end

   // Conversion sequencer: a start always reloads, even mid-conversion or on the final step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_r   <= 27'd0;
         acc_r  <= 36'd0;
         cnt_r  <= 5'd0;
         dec_r  <= 32'd0;
         ok_r   <= 1'b0;
         busy_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (st) begin
         sh_r   <= BIN;
         acc_r  <= 36'd0;
         cnt_r  <= 5'd0;
         busy_r <= 1'b1;
         ok_r   <= 1'b0;
      end else if (busy_r) begin
         sh_r  <= sh_next_s;
         acc_r <= acc_next_s;
         cnt_r <= cnt_r + 5'd1;
         if (cnt_r == 5'd26) begin
            busy_r <= 1'b0;
            ok_r   <= 1'b1;
            dec_r  <= res_dec_s;
            ovf_r  <= res_ovf_s;
         end else begin
            ok_r <= 1'b0;
         end
      end else begin
         ok_r <= 1'b0;
      end
   end

   assign DEC  = dec_r;
   assign ok   = ok_r;
   assign busy = busy_r;
   assign ovf  = ovf_r;

endmodule
